rr_pkt_input_arbiter: RTL and testbench
=======================================

# rr_pkt_input_arbiter

Packet-granular round-robin arbiter that merges NUM_INPUTS upstream packet streams into the single datapath stream consumed by the user data path and, ultimately, the output queues. Each input has a small fall-through buffer. A granted input is drained one whole packet at a time onto a registered output bus. This block is the write side of the `out_data/out_ctrl/out_wr/out_rdy` handshake that the output-queue stage receives on its `in_*` ports.

## Interface

**Parameters**
- `DATA_WIDTH`, 64: data word width.
- `CTRL_WIDTH`, DATA_WIDTH/8: control word width. Non-zero marks a module-header or EOP word.
- `NUM_INPUTS`, 8: number of input streams. Must be at least 2.
- `IN_FIFO_DEPTH_BITS`, 3: per-input buffer depth is 2**IN_FIFO_DEPTH_BITS words.

**Ports**
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  NUM_INPUTS*DATA_WIDTH  packed data words; input i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- `in_ctrl`  in  NUM_INPUTS*CTRL_WIDTH  packed control words, same packing as `in_data`.
- `in_wr`  in  NUM_INPUTS  per-input write strobe.
- `in_rdy`  out  NUM_INPUTS  per-input ready; high = buffer may accept a word.
- `in_disable`  in  NUM_INPUTS  per-input mask; quasi-static, sampled only at grant time.
- `out_data`  out  DATA_WIDTH  merged data word, registered.
- `out_ctrl`  out  CTRL_WIDTH  merged control word, registered.
- `out_wr`  out  1  output word valid, registered.
- `out_rdy`  in  1  downstream can accept a word.
- `pkt_done`  out  1  one-cycle pulse when an EOP word is presented on `out_*`.
- `pkt_src`  out  log2(NUM_INPUTS)  source index of the current or last packet; valid while `out_wr` is high.
- `overflow`  out  NUM_INPUTS  one-cycle pulse per input when a write hits a full buffer; the word is discarded.

## Operation

**Input buffers**
- One fall-through FIFO per input, storing {ctrl, data}.
- `in_rdy[i]` = occupancy < depth-1. This leaves one word of slack for a writer that samples `in_rdy` one cycle late.
- A write while the buffer is full: word dropped, `overflow[i]` pulses the next cycle, occupancy unchanged.
- Simultaneous write and read on a full buffer: the read frees a slot, the write is accepted, and there is no overflow.

**Arbiter FSM, two states**
- `IDLE`
  - Search inputs `last+1, last+2, …` modulo NUM_INPUTS (wrap-around) for the first one that is non-empty and not `in_disable`.
  - On a hit: register `grant` ← index, `ctrl_prev` ← 1, go to `SEND`.
  - No hit: stay in `IDLE`.
- `SEND`
  - Pop condition: buffer[grant] non-empty AND `out_rdy`. On a pop the word is registered to `out_*`, `out_wr`=1 on the next cycle, and `ctrl_prev` ← popped ctrl.
  - EOP = popped ctrl ≠ 0 AND `ctrl_prev` == 0. On EOP: `last` ← grant, `pkt_done` pulses alongside that word's `out_wr`, go to `IDLE`.
  - An empty granted buffer mid-packet stalls the FSM in `SEND`; no other input is served.
- Leading header words (ctrl ≠ 0) never end a packet, because `ctrl_prev` starts at 1 on grant.
- `in_disable` asserted mid-packet: the current packet completes; the mask takes effect only at the next grant.

**Reset (`reset_n` low)**
- FIFOs emptied; state = `IDLE`; `last` = NUM_INPUTS-1, so input 0 wins the first grant.
- `out_wr`=0, `out_data`=0, `out_ctrl`=0, `pkt_done`=0, `pkt_src`=0, `overflow`=0.
- After reset, `in_rdy` is all ones.
- Reset mid-packet discards all buffered words. No partial packet is resumed.

## Timing
- `in_wr` at cycle 0 into an empty buffer with the FSM in `IDLE`:
  - buffer non-empty at cycle 1, grant at cycle 1;
  - `SEND` and pop at cycle 2;
  - `out_wr` at cycle 3.
- Within a packet: one word per cycle while the buffer is non-empty and `out_rdy`=1.
- Between packets: EOP popped at cycle n, `IDLE` at n+1, next pop at n+2. This gives exactly one idle output cycle.
- `out_rdy` deasserted at cycle k: no pop at k. At most the word popped at k-1 appears at k. Downstream must absorb one word after dropping `out_rdy`.
- `out_data` and `out_ctrl` hold their last value when `out_wr`=0.

## Test plan
- **Single packet.** Reset, then on input 2 write 2 headers (ctrl 0xFF), 3 data words (ctrl 0), and an EOP (ctrl 0x01). Expect 6 contiguous `out_wr` cycles starting 3 cycles after the first `in_wr`, words in order, `pkt_src`=2, and `pkt_done` only on the last word.
- **Round-robin fairness.** Inputs 0, 3 and 7 each hold 2 one-word-data packets. Expect output order 0, 3, 7, 0, 3, 7, one idle cycle between packets, and index 7 wrapping to 0.
- **Backpressure.** Drop `out_rdy` for 4 cycles mid-packet. Expect at most 1 word after the drop, no loss or duplication, and the packet completing intact.
- **Overflow.** Hold `out_rdy`=0 and write 9 words to input 1 at depth 8. Expect `in_rdy[1]` low after 7 words, the 9th word dropped with an `overflow[1]` pulse, and 8 words later delivered.
- **Disable and reset.** Set `in_disable[0]`=1 with inputs 0 and 1 loaded: only input 1 is served. Assert `reset_n`=0 mid-packet: outputs go to 0 immediately, and after release input 0 wins the first grant.

Source files
------------

// File: rtl/rr_pkt_input_arbiter_if.sv
// rr_pkt_input_arbiter_if: upstream packet streams and merged output handshake
interface rr_pkt_input_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH/8,
    parameter int NUM_INPUTS = 8
);
    localparam int SW = $clog2(NUM_INPUTS);
    logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data;
    logic [NUM_INPUTS*CTRL_WIDTH-1:0] in_ctrl;
    logic [NUM_INPUTS-1:0]            in_wr;
    logic [NUM_INPUTS-1:0]            in_rdy;
    logic [NUM_INPUTS-1:0]            in_disable;
    logic [DATA_WIDTH-1:0]            out_data;
    logic [CTRL_WIDTH-1:0]            out_ctrl;
    logic                             out_wr;
    logic                             out_rdy;
    logic                             pkt_done;
    logic [SW-1:0]                    pkt_src;
    logic [NUM_INPUTS-1:0]            overflow;
    modport master (
        output in_data, in_ctrl, in_wr, in_disable, out_rdy,
        input  in_rdy, out_data, out_ctrl, out_wr, pkt_done, pkt_src, overflow
    );
    modport slave (
        input  in_data, in_ctrl, in_wr, in_disable, out_rdy,
        output in_rdy, out_data, out_ctrl, out_wr, pkt_done, pkt_src, overflow
    );
endinterface

// File: rtl/rr_pkt_input_arbiter.sv
// rr_pkt_input_arbiter: packet-granular round-robin merge of buffered input streams
module rr_pkt_input_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH/8,
    parameter int NUM_INPUTS = 8,
    parameter int IN_FIFO_DEPTH_BITS = 3
) (
    input logic clk,
    input logic reset_n,
    rr_pkt_input_arbiter_if.slave bus
);
    localparam int SW = $clog2(NUM_INPUTS);
    localparam int AW = IN_FIFO_DEPTH_BITS;
    localparam int CW = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam int WW = CTRL_WIDTH + DATA_WIDTH;
    typedef enum logic {IDLE, SEND} state_t;
    state_t state;
    logic [WW-1:0] mem [NUM_INPUTS][DEPTH];
    logic [AW-1:0] wr_ptr [NUM_INPUTS];
    logic [AW-1:0] rd_ptr [NUM_INPUTS];
    logic [CW-1:0] count [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] empty, rdy, acc, ovf, pop_v;
    logic [SW-1:0] grant, last, nxt, idx;
    logic [WW-1:0] head;
    logic hit, ctrl_prev, pop, eop;

    assign bus.in_rdy = rdy;

    // Buffer status, head-of-line word, pop/EOP decode and the round-robin search from last+1
    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            empty[i] = count[i] == '0;
            rdy[i] = count[i] < CW'(DEPTH - 1);
        end
        head = mem[grant][rd_ptr[grant]];
        pop = state == SEND && !empty[grant] && bus.out_rdy;
        eop = head[WW-1:DATA_WIDTH] != '0 && !ctrl_prev;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            pop_v[i] = pop && grant == SW'(i);
            acc[i] = bus.in_wr[i] && (count[i] != CW'(DEPTH) || pop_v[i]);
            ovf[i] = bus.in_wr[i] && count[i] == CW'(DEPTH) && !pop_v[i];
        end
        hit = 1'b0;
        nxt = last;
        idx = last;
        for (int k = NUM_INPUTS; k >= 1; k--) begin
            idx = SW'((int'(last) + k) % NUM_INPUTS);
            if (!empty[idx] && !bus.in_disable[idx]) begin
                hit = 1'b1;
                nxt = idx;
            end
        end
    end

    // Buffer storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_INPUTS; i++)
            if (acc[i]) mem[i][wr_ptr[i]] <= {bus.in_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH], bus.in_data[i*DATA_WIDTH +: DATA_WIDTH]};
    end

    // Buffer pointers, occupancy and the registered overflow pulse for dropped writes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i] <= '0;
            end
            bus.overflow <= '0;
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (acc[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop_v[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
                count[i] <= count[i] + CW'(acc[i]) - CW'(pop_v[i]);
            end
            bus.overflow <= ovf;
        end
    end

    // Arbiter FSM: grant in IDLE, drain one whole packet in SEND onto the registered output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            grant <= '0;
            last <= SW'(NUM_INPUTS - 1);
            ctrl_prev <= 1'b1;
            bus.out_wr <= 1'b0;
            bus.out_data <= '0;
            bus.out_ctrl <= '0;
            bus.pkt_done <= 1'b0;
            bus.pkt_src <= '0;
        end else begin
            bus.out_wr <= pop;
            bus.pkt_done <= pop && eop;
            if (pop) begin
                bus.out_data <= head[DATA_WIDTH-1:0];
                bus.out_ctrl <= head[WW-1:DATA_WIDTH];
                bus.pkt_src <= grant;
                ctrl_prev <= head[WW-1:DATA_WIDTH] != '0;
            end
            if (state == IDLE && hit) begin
                grant <= nxt;
                ctrl_prev <= 1'b1;
                state <= SEND;
            end else if (pop && eop) begin
                last <= grant;
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_rr_pkt_input_arbiter.sv
// tb_rr_pkt_input_arbiter: scoreboard bench for the round-robin packet arbiter
module tb_rr_pkt_input_arbiter;
    typedef struct packed {
        logic [2:0]  src;
        logic [7:0]  ctrl;
        logic [63:0] data;
        logic        eop;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    int oc[$];

    rr_pkt_input_arbiter_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .NUM_INPUTS(8)) bus ();

    rr_pkt_input_arbiter #(
        .DATA_WIDTH(64), .CTRL_WIDTH(8), .NUM_INPUTS(8), .IN_FIFO_DEPTH_BITS(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used for latency and gap checks
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every presented word must match the head of the scoreboard
    always @(negedge clk) begin
        if (reset_n && bus.out_wr) begin
            oc.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out src=%0d ctrl=%h data=%h required=none", bus.pkt_src, bus.out_ctrl, bus.out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({bus.pkt_src, bus.out_ctrl, bus.out_data, bus.pkt_done} !== {e.src, e.ctrl, e.data, e.eop}) begin
                    errors++;
                    $display("FAIL sb_word got src=%0d ctrl=%h data=%h done=%b required src=%0d ctrl=%h data=%h done=%b",
                             bus.pkt_src, bus.out_ctrl, bus.out_data, bus.pkt_done, e.src, e.ctrl, e.data, e.eop);
                end
            end
        end
    end

    function automatic logic [63:0] dat(input int src, input int tag);
        return {8'(src), 56'(tag)};
    endfunction

    task automatic push(input int src, input logic [7:0] c, input int tag, input logic e);
        exp_t w;
        w.src = 3'(src);
        w.ctrl = c;
        w.data = dat(src, tag);
        w.eop = e;
        sb.push_back(w);
    endtask

    task automatic drive(input logic [7:0] m, input logic [7:0] c, input int tag);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            bus.in_data[i*64 +: 64] = dat(i, tag);
            bus.in_ctrl[i*8 +: 8] = c;
        end
        bus.in_wr = m;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.in_wr = '0;
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain left=%0d required=0", nm, sb.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.out_wr, bus.pkt_done, bus.out_data, bus.out_ctrl, bus.pkt_src, bus.overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got wr=%b done=%b data=%h ctrl=%h src=%0d ovf=%h required all zero",
                     bus.out_wr, bus.pkt_done, bus.out_data, bus.out_ctrl, bus.pkt_src, bus.overflow);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.in_rdy !== 8'hFF) begin
            errors++;
            $display("FAIL reset_in_rdy got=%h required=ff", bus.in_rdy);
        end
        checks++;
        if (bus.out_wr !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_wr got=%b required=0", bus.out_wr);
        end
    endtask

    task automatic test_round_robin();
        oc.delete();
        for (int p = 0; p < 2; p++) begin
            push(0, 8'h00, 10 + 2*p, 1'b0); push(0, 8'h01, 11 + 2*p, 1'b1);
            push(3, 8'h00, 10 + 2*p, 1'b0); push(3, 8'h01, 11 + 2*p, 1'b1);
            push(7, 8'h00, 10 + 2*p, 1'b0); push(7, 8'h01, 11 + 2*p, 1'b1);
        end
        drive(8'h89, 8'h00, 10);
        drive(8'h89, 8'h01, 11);
        drive(8'h89, 8'h00, 12);
        drive(8'h89, 8'h01, 13);
        idle();
        wait_drain("rr");
        checks++;
        if (oc.size() != 12) begin
            errors++;
            $display("FAIL rr_count got=%0d required=12", oc.size());
        end else begin
            for (int j = 0; j < 6; j++) begin
                checks++;
                if (oc[2*j+1] != oc[2*j] + 1) begin
                    errors++;
                    $display("FAIL rr_contig pkt=%0d got=%0d required=%0d", j, oc[2*j+1] - oc[2*j], 1);
                end
                if (j > 0) begin
                    checks++;
                    if (oc[2*j] != oc[2*j-1] + 2) begin
                        errors++;
                        $display("FAIL rr_gap pkt=%0d got=%0d required=%0d", j, oc[2*j] - oc[2*j-1], 2);
                    end
                end
            end
        end
    endtask

    task automatic test_single_packet();
        int c0;
        oc.delete();
        push(2, 8'hFF, 1, 1'b0); push(2, 8'hFF, 2, 1'b0);
        push(2, 8'h00, 3, 1'b0); push(2, 8'h00, 4, 1'b0); push(2, 8'h00, 5, 1'b0);
        push(2, 8'h01, 6, 1'b1);
        drive(8'h04, 8'hFF, 1);
        c0 = cyc;
        drive(8'h04, 8'hFF, 2);
        drive(8'h04, 8'h00, 3);
        drive(8'h04, 8'h00, 4);
        drive(8'h04, 8'h00, 5);
        drive(8'h04, 8'h01, 6);
        idle();
        wait_drain("single");
        checks++;
        if (oc.size() != 6) begin
            errors++;
            $display("FAIL single_count got=%0d required=6", oc.size());
        end else begin
            checks++;
            if (oc[0] != c0 + 3) begin
                errors++;
                $display("FAIL single_latency got=%0d required=%0d", oc[0] - c0, 3);
            end
            checks++;
            if (oc[5] != oc[0] + 5) begin
                errors++;
                $display("FAIL single_contig got=%0d required=%0d", oc[5] - oc[0], 5);
            end
        end
    endtask

    task automatic test_backpressure();
        int k;
        int n;
        oc.delete();
        push(4, 8'hFF, 20, 1'b0);
        for (int t = 21; t < 25; t++) push(4, 8'h00, t, 1'b0);
        push(4, 8'h01, 25, 1'b1);
        drive(8'h10, 8'hFF, 20);
        for (int t = 21; t < 25; t++) drive(8'h10, 8'h00, t);
        drive(8'h10, 8'h01, 25);
        bus.out_rdy = 1'b0;
        k = cyc;
        idle();
        repeat (3) begin
            @(posedge clk); #1;
        end
        bus.out_rdy = 1'b1;
        wait_drain("bp");
        n = 0;
        foreach (oc[i]) if (oc[i] >= k && oc[i] <= k + 3) n++;
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL bp_after_drop got=%0d required=1", n);
        end
        checks++;
        if (oc.size() != 6) begin
            errors++;
            $display("FAIL bp_count got=%0d required=6", oc.size());
        end
    endtask

    task automatic test_overflow();
        logic [7:0] c;
        oc.delete();
        bus.out_rdy = 1'b0;
        for (int i = 0; i < 8; i++) push(1, i == 0 ? 8'hFF : (i == 7 ? 8'h01 : 8'h00), 30 + i, i == 7);
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.in_rdy[1] !== (i < 7)) begin
                errors++;
                $display("FAIL ovf_in_rdy step=%0d got=%b required=%b", i, bus.in_rdy[1], i < 7);
            end
            checks++;
            if (bus.overflow !== (i == 9 ? 8'h02 : 8'h00)) begin
                errors++;
                $display("FAIL ovf_pulse step=%0d got=%h required=%h", i, bus.overflow, i == 9 ? 8'h02 : 8'h00);
            end
            c = i == 0 ? 8'hFF : (i == 7 ? 8'h01 : 8'h00);
            bus.in_data[64 +: 64] = dat(1, 30 + i);
            bus.in_ctrl[8 +: 8] = c;
            bus.in_wr = i < 9 ? 8'h02 : 8'h00;
        end
        bus.out_rdy = 1'b1;
        wait_drain("ovf");
        checks++;
        if (oc.size() != 8) begin
            errors++;
            $display("FAIL ovf_count got=%0d required=8", oc.size());
        end
    endtask

    task automatic test_disable();
        oc.delete();
        bus.in_disable = 8'h01;
        push(1, 8'h00, 40, 1'b0); push(1, 8'h01, 41, 1'b1);
        drive(8'h03, 8'h00, 40);
        drive(8'h03, 8'h01, 41);
        idle();
        wait_drain("dis");
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (oc.size() != 2) begin
            errors++;
            $display("FAIL dis_count got=%0d required=2", oc.size());
        end
    endtask

    task automatic test_reset_mid_packet();
        oc.delete();
        push(2, 8'hFF, 50, 1'b0);
        for (int t = 51; t < 55; t++) push(2, 8'h00, t, 1'b0);
        push(2, 8'h01, 55, 1'b1);
        drive(8'h04, 8'hFF, 50);
        for (int t = 51; t < 55; t++) drive(8'h04, 8'h00, t);
        drive(8'h04, 8'h01, 55);
        idle();
        checks++;
        if (oc.size() != 3) begin
            errors++;
            $display("FAIL rst_pre_count got=%0d required=3", oc.size());
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_wr, bus.pkt_done, bus.out_data, bus.out_ctrl, bus.pkt_src} !== '0) begin
            errors++;
            $display("FAIL rst_async got wr=%b done=%b data=%h ctrl=%h src=%0d required all zero",
                     bus.out_wr, bus.pkt_done, bus.out_data, bus.out_ctrl, bus.pkt_src);
        end
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.in_rdy !== 8'hFF) begin
            errors++;
            $display("FAIL rst_in_rdy got=%h required=ff", bus.in_rdy);
        end
        bus.in_disable = 8'h00;
        reset_n = 1'b1;
        oc.delete();
        push(0, 8'h00, 60, 1'b0); push(0, 8'h01, 61, 1'b1);
        push(1, 8'h00, 60, 1'b0); push(1, 8'h01, 61, 1'b1);
        drive(8'h03, 8'h00, 60);
        drive(8'h03, 8'h01, 61);
        idle();
        wait_drain("rst");
        checks++;
        if (oc.size() != 4) begin
            errors++;
            $display("FAIL rst_post_count got=%0d required=4", oc.size());
        end
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Test sequence
    initial begin
        bus.in_data = '0;
        bus.in_ctrl = '0;
        bus.in_wr = '0;
        bus.in_disable = '0;
        bus.out_rdy = 1'b1;
        test_reset();
        test_round_robin();
        test_single_packet();
        test_backpressure();
        test_overflow();
        test_disable();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
